// File: rtl/ntcrack_pkg.sv
// Shared definitions for the NT hash cracker host: controller state encoding,
// transfer sizes and byte-lane helpers used by the host and its sub-blocks.
package ntcrack_pkg;

  localparam int HASH_BYTES = 16;  // bytes in one NT hash
  localparam int PWD_BYTES  = 20;  // password bytes returned by the core
  localparam int RX_BYTES   = 21;  // password bytes plus one length byte

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LD_SET,
    ST_LD_ACK,
    ST_LD_REL,
    ST_GO_SET,
    ST_GO_ACK,
    ST_SEARCH,
    ST_RX_ACK,
    ST_RX_REL,
    ST_RESULT,
    ST_ERR
  } state_t;

  // Byte i of a hash, most significant byte first.
  function automatic logic [7:0] hash_byte(input logic [127:0] h, input logic [3:0] i);
    return h[(HASH_BYTES - 1 - int'(i)) * 8 +: 8];
  endfunction

  // Return p with password byte k (0 = most significant) replaced by b.
  function automatic logic [159:0] pwd_put(input logic [159:0] p, input logic [4:0] k,
                                           input logic [7:0] b);
    logic [159:0] r;
    r = p;
    r[(PWD_BYTES - 1 - int'(k)) * 8 +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/ntcrack_host_if.sv
// Bundle of every signal between the cracker host, its upstream/downstream
// users and the cracking core. The host itself uses the slave view; the
// surrounding system (or a bench) uses the master view.
interface ntcrack_host_if;

  // upstream hash stream
  logic         hash_valid;
  logic         hash_ready;
  logic [127:0] hash_data;
  // search control
  logic         start;
  logic         busy;
  logic         done;
  // result stream
  logic         result_valid;
  logic         result_ready;
  logic [159:0] result_password;
  logic [4:0]   result_len;
  // core side
  logic [7:0]   new_hash_byte;
  logic         store_hash_byte;
  logic         go;
  logic         your_turn;
  logic         match_found;
  logic [7:0]   password_byte;
  // status
  logic [6:0]   hash_count;
  logic         error;

  modport slave (
    input  hash_valid, hash_data, start, result_ready,
           your_turn, match_found, password_byte,
    output hash_ready, busy, done, result_valid, result_password, result_len,
           new_hash_byte, store_hash_byte, go, hash_count, error
  );

  modport master (
    output hash_valid, hash_data, start, result_ready,
           your_turn, match_found, password_byte,
    input  hash_ready, busy, done, result_valid, result_password, result_len,
           new_hash_byte, store_hash_byte, go, hash_count, error
  );

endinterface

// File: rtl/ntcrack_hs_strobe.sv
// Four-phase strobe toward the core: raise, wait for your_turn low, drop,
// wait for your_turn high. One instance drives store_hash_byte, one drives go.
// acked flags the cycle in which the strobe is dropped; released flags that
// the core has handed the turn back after the last drop.
module ntcrack_hs_strobe (
  input  logic clk,
  input  logic nrst,
  input  logic raise,      // start a new handshake
  input  logic abort,      // force the strobe low (watchdog)
  input  logic your_turn,
  output logic strobe,
  output logic acked,
  output logic released
);

  logic strobe_reg, strobe_next;
  logic wait_hi_reg, wait_hi_next;

  assign strobe   = strobe_reg;
  assign acked    = strobe_reg & ~your_turn;
  assign released = wait_hi_reg & your_turn;

  // Next strobe/phase: abort beats raise, raise beats the core's acknowledge.
  always_comb begin
    strobe_next  = strobe_reg;
    wait_hi_next = wait_hi_reg;
    if (abort) begin
      strobe_next  = 1'b0;
      wait_hi_next = 1'b0;
    end else if (raise) begin
      strobe_next  = 1'b1;
      wait_hi_next = 1'b0;
    end else if (strobe_reg && !your_turn) begin
      strobe_next  = 1'b0;
      wait_hi_next = 1'b1;
    end
  end

  // Strobe and phase registers.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      strobe_reg  <= 1'b0;
      wait_hi_reg <= 1'b0;
    end else begin
      strobe_reg  <= strobe_next;
      wait_hi_reg <= wait_hi_next;
    end
  end

endmodule

// File: rtl/ntcrack_host.sv
// Host controller for the NT hash cracking core. Loads hashes byte by byte
// into the core, launches a search and collects each 21-byte result
// (20 password bytes + length) into a held result record.
// Optional build macro NTCRACK_HOST_TIMEOUT_EN adds a handshake watchdog that
// moves to a sticky error state after TMO_CYCLES stalled cycles; without it
// the handshakes wait indefinitely and error is tied low.
module ntcrack_host
  import ntcrack_pkg::*;
#(
  parameter int HASH_MAX   = 64,
  parameter int TMO_CYCLES = 16'hFFFF
) (
  input  logic          clk,
  input  logic          nrst,
  ntcrack_host_if.slave bus
);

  state_t         state_reg, state_next;
  logic [127:0]   hash_reg, hash_next;
  logic [3:0]     byte_idx_reg, byte_idx_next;
  logic [6:0]     hash_count_reg, hash_count_next;
  logic           busy_reg, busy_next;
  logic           done_reg, done_next;
  logic [4:0]     rx_idx_reg, rx_idx_next;
  logic [159:0]   pwd_reg, pwd_next;
  logic [4:0]     len_reg, len_next;

  logic           hash_ready;
  logic           ld_raise, ld_acked, ld_released;
  logic           go_raise, go_acked, go_released;
  logic           cap_en;
  logic [4:0]     cap_idx;
  logic           tmo_hit;

  assign hash_ready = (state_reg == ST_IDLE) && bus.your_turn &&
                      (int'(hash_count_reg) < HASH_MAX);

  assign bus.hash_ready      = hash_ready;
  assign bus.busy            = busy_reg;
  assign bus.done            = done_reg;
  assign bus.result_valid    = (state_reg == ST_RESULT);
  assign bus.result_password = pwd_reg;
  assign bus.result_len      = len_reg;
  assign bus.new_hash_byte   = hash_byte(hash_reg, byte_idx_reg);
  assign bus.hash_count      = hash_count_reg;

  // store_hash_byte and go come from separate strobes; the FSM only ever
  // raises one of them and waits for it to complete, so they never overlap.
  ntcrack_hs_strobe u_store_hs (
    .clk       (clk),
    .nrst      (nrst),
    .raise     (ld_raise),
    .abort     (tmo_hit),
    .your_turn (bus.your_turn),
    .strobe    (bus.store_hash_byte),
    .acked     (ld_acked),
    .released  (ld_released)
  );

  ntcrack_hs_strobe u_go_hs (
    .clk       (clk),
    .nrst      (nrst),
    .raise     (go_raise),
    .abort     (tmo_hit),
    .your_turn (bus.your_turn),
    .strobe    (bus.go),
    .acked     (go_acked),
    .released  (go_released)
  );

`ifdef NTCRACK_HOST_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TMO_CYCLES - 1);

  logic [15:0] tmo_cnt_reg;
  logic        error_reg;
  logic        timed;

  assign timed   = state_reg inside {ST_LD_ACK, ST_LD_REL, ST_GO_ACK, ST_RX_ACK, ST_RX_REL};
  assign tmo_hit = timed && (tmo_cnt_reg == TMO_LAST);
  assign bus.error = error_reg;

  // Count consecutive cycles stuck in one handshake state; restart on progress.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      tmo_cnt_reg <= '0;
    end else if (!timed || (state_next != state_reg)) begin
      tmo_cnt_reg <= '0;
    end else begin
      tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
    end
  end

  // Sticky error flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      error_reg <= 1'b0;
    end else if (tmo_hit) begin
      error_reg <= 1'b1;
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign bus.error = 1'b0;
`endif

  // Controller next-state logic; a hash accept takes priority over start.
  always_comb begin
    state_next      = state_reg;
    hash_next       = hash_reg;
    byte_idx_next   = byte_idx_reg;
    hash_count_next = hash_count_reg;
    busy_next       = busy_reg;
    done_next       = 1'b0;
    rx_idx_next     = rx_idx_reg;
    ld_raise        = 1'b0;
    go_raise        = 1'b0;
    cap_en          = 1'b0;
    cap_idx         = rx_idx_reg;

    if (tmo_hit) begin
      state_next = ST_ERR;
      busy_next  = 1'b0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (bus.hash_valid && hash_ready) begin
            hash_next     = bus.hash_data;
            byte_idx_next = '0;
            state_next    = ST_LD_SET;
          end else if (bus.start) begin
            busy_next  = 1'b1;
            state_next = ST_GO_SET;
          end
        end
        ST_LD_SET: begin
          ld_raise   = 1'b1;
          state_next = ST_LD_ACK;
        end
        ST_LD_ACK: begin
          if (ld_acked) state_next = ST_LD_REL;
        end
        ST_LD_REL: begin
          if (ld_released) begin
            if (byte_idx_reg != 4'(HASH_BYTES - 1)) begin
              byte_idx_next = byte_idx_reg + 4'd1;
              state_next    = ST_LD_SET;
            end else begin
              hash_count_next = hash_count_reg + 7'd1;
              state_next      = ST_IDLE;
            end
          end
        end
        ST_GO_SET: begin
          go_raise   = 1'b1;
          state_next = ST_GO_ACK;
        end
        ST_GO_ACK: begin
          if (go_acked) state_next = ST_SEARCH;
        end
        ST_SEARCH: begin
          if (bus.your_turn) begin
            if (bus.match_found) begin
              cap_en      = 1'b1;
              cap_idx     = 5'd0;
              rx_idx_next = 5'd1;
              go_raise    = 1'b1;
              state_next  = ST_RX_ACK;
            end else begin
              done_next  = 1'b1;
              busy_next  = 1'b0;
              state_next = ST_IDLE;
            end
          end
        end
        ST_RX_ACK: begin
          if (go_acked) state_next = ST_RX_REL;
        end
        ST_RX_REL: begin
          if (rx_idx_reg == 5'(RX_BYTES)) begin
            state_next = ST_RESULT;
          end else if (go_released && bus.match_found) begin
            cap_en      = 1'b1;
            rx_idx_next = rx_idx_reg + 5'd1;
            go_raise    = 1'b1;
            state_next  = ST_RX_ACK;
          end
        end
        ST_RESULT: begin
          if (bus.result_ready) state_next = ST_SEARCH;
        end
        ST_ERR: begin
          state_next = ST_ERR;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Place a captured byte: bytes 0..19 into the password, byte 20 is the length.
  always_comb begin
    pwd_next = pwd_reg;
    len_next = len_reg;
    if (cap_en) begin
      if (int'(cap_idx) < PWD_BYTES) begin
        pwd_next = pwd_put(pwd_reg, cap_idx, bus.password_byte);
      end else begin
        len_next = bus.password_byte[4:0];
      end
    end
  end

  // Controller registers.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_reg      <= ST_IDLE;
      hash_reg       <= '0;
      byte_idx_reg   <= '0;
      hash_count_reg <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      rx_idx_reg     <= '0;
      pwd_reg        <= '0;
      len_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      hash_reg       <= hash_next;
      byte_idx_reg   <= byte_idx_next;
      hash_count_reg <= hash_count_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      rx_idx_reg     <= rx_idx_next;
      pwd_reg        <= pwd_next;
      len_reg        <= len_next;
    end
  end

endmodule

// File: tb/tb_ntcrack_host.sv
// Directed bench for ntcrack_host with a small behavioural cracking core.
// The core model answers on the falling edge; the bench drives and samples
// 1 time unit after the rising edge.
module tb_ntcrack_host;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  ntcrack_host_if bus();

  ntcrack_host #(.HASH_MAX(64), .TMO_CYCLES(16)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- core model ----------------
  logic       stall = 1'b0;
  int         store_total = 0;
  int         go_total = 0;
  logic [7:0] store_log [0:2047];
  logic [7:0] tx_bytes [0:20];
  int         tx_len = 0;
  int         tx_idx = 0;
  logic       last_go = 1'b0;
  logic       overlap = 1'b0;

  always @(negedge clk) begin
    if (!nrst) begin
      bus.your_turn = 1'b1;
      bus.match_found = 1'b0;
      bus.password_byte = 8'h00;
      tx_idx = 0;
      last_go = 1'b0;
    end else begin
      if (bus.go && bus.store_hash_byte) overlap = 1'b1;
      if (bus.go || bus.store_hash_byte) begin
        if (bus.your_turn && !stall) begin
          bus.your_turn = 1'b0;
          last_go = bus.go;
          if (bus.store_hash_byte) begin
            store_log[store_total[10:0]] = bus.new_hash_byte;
            store_total++;
          end
          if (bus.go) go_total++;
        end
      end else if (!bus.your_turn) begin
        bus.your_turn = 1'b1;
        if (last_go) begin
          if (tx_idx < tx_len) begin
            bus.match_found = 1'b1;
            bus.password_byte = tx_bytes[tx_idx];
            tx_idx++;
          end else begin
            bus.match_found = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one hash and wait until hash_count moves; ok=0 if a bound expires.
  task automatic load_hash(input logic [127:0] h, output bit ok);
    int t;
    logic [6:0] c0;
    ok = 1'b1;
    t = 0;
    while (bus.hash_ready !== 1'b1 && t < 100) begin tick(); t++; end
    if (t >= 100) ok = 1'b0;
    c0 = bus.hash_count;
    bus.hash_valid = 1'b1;
    bus.hash_data = h;
    tick();
    bus.hash_valid = 1'b0;
    t = 0;
    while (bus.hash_count === c0 && t < 200) begin tick(); t++; end
    if (t >= 200) ok = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    nrst = 1'b0;
    bus.hash_valid = 1'b0;
    bus.hash_data = '0;
    bus.start = 1'b0;
    bus.result_ready = 1'b0;
    repeat (4) tick();
    n_cmp++;
    if ({bus.busy, bus.done, bus.go, bus.store_hash_byte, bus.result_valid, bus.error} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got busy/done/go/store/rv/err=%b want 000000",
               {bus.busy, bus.done, bus.go, bus.store_hash_byte, bus.result_valid, bus.error});
    end
    n_cmp++;
    if (bus.hash_count !== 7'd0) begin
      n_bad++; $display("FAIL reset_hash_count: got %0d want 0", bus.hash_count);
    end
    n_cmp++;
    if (bus.result_password !== 160'd0 || bus.result_len !== 5'd0) begin
      n_bad++; $display("FAIL reset_result: got pwd=%h len=%0d want 0/0", bus.result_password, bus.result_len);
    end
    n_cmp++;
    if (bus.new_hash_byte !== 8'h00) begin
      n_bad++; $display("FAIL reset_hash_byte: got %h want 00", bus.new_hash_byte);
    end
    nrst = 1'b1;
    tick();
    n_cmp++;
    if (bus.hash_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_hash_ready: got %b want 1", bus.hash_ready);
    end
    $display("reset done");
  endtask

  task automatic test_load_one();
    logic [127:0] h;
    logic [127:0] sh;
    int s0;
    int nbad_bytes;
    bit ok;
    h = 128'h31D6CFE0D16AE931B73C59D7E0C089C0;
    s0 = store_total;
    load_hash(h, ok);
    $display("load hash %h", h);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL load_one_timeout: got timeout want completion"); end
    n_cmp++;
    if (store_total - s0 != 16) begin
      n_bad++; $display("FAIL load_one_strobes: got %0d want 16", store_total - s0);
    end
    nbad_bytes = 0;
    for (int j = 0; j < 16; j++) begin
      sh = h >> (8 * (15 - j));
      if (store_log[11'(s0 + j)] !== sh[7:0]) nbad_bytes++;
    end
    n_cmp++;
    if (nbad_bytes != 0) begin
      n_bad++; $display("FAIL load_one_bytes: got %0d wrong bytes (first %h) want 0 (first 31)",
                        nbad_bytes, store_log[11'(s0)]);
    end
    n_cmp++;
    if (bus.hash_count !== 7'd1) begin
      n_bad++; $display("FAIL load_one_count: got %0d want 1", bus.hash_count);
    end
  endtask

  task automatic test_fill();
    logic [127:0] h;
    logic [127:0] sh;
    int s0;
    int loads_bad;
    int bytes_bad;
    bit ok;
    bit ready_seen;
    loads_bad = 0;
    bytes_bad = 0;
    for (int i = 1; i < 64; i++) begin
      h = {16{8'(i)}} ^ 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
      s0 = store_total;
      load_hash(h, ok);
      if (!ok || store_total - s0 != 16) loads_bad++;
      for (int j = 0; j < 16; j++) begin
        sh = h >> (8 * (15 - j));
        if (store_log[11'(s0 + j)] !== sh[7:0]) bytes_bad++;
      end
      $display("load hash %0d %h count=%0d", i, h, bus.hash_count);
    end
    n_cmp++;
    if (loads_bad != 0) begin n_bad++; $display("FAIL fill_loads: got %0d bad loads want 0", loads_bad); end
    n_cmp++;
    if (bytes_bad != 0) begin n_bad++; $display("FAIL fill_bytes: got %0d bad bytes want 0", bytes_bad); end
    n_cmp++;
    if (bus.hash_count !== 7'd64) begin
      n_bad++; $display("FAIL fill_count: got %0d want 64", bus.hash_count);
    end
    // Full: a waiting hash must not be taken.
    s0 = store_total;
    ready_seen = 1'b0;
    bus.hash_valid = 1'b1;
    bus.hash_data = 128'hDEADBEEF;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.hash_ready !== 1'b0) ready_seen = 1'b1;
    end
    bus.hash_valid = 1'b0;
    n_cmp++;
    if (ready_seen) begin n_bad++; $display("FAIL full_ready: got hash_ready=1 want 0"); end
    n_cmp++;
    if (bus.hash_count !== 7'd64 || store_total != s0) begin
      n_bad++; $display("FAIL full_no_load: got count=%0d strobes=%0d want 64/0", bus.hash_count, store_total - s0);
    end
  endtask

  task automatic test_search_match();
    int g0;
    int t;
    logic [143:0] spaces;
    spaces = {18{8'h20}};
    tx_bytes[0] = 8'h61;
    tx_bytes[1] = 8'h62;
    for (int k = 2; k < 20; k++) tx_bytes[k] = 8'h20;
    tx_bytes[20] = 8'h02;
    tx_len = 21;
    g0 = go_total;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL start_busy: got %b want 1", bus.busy); end
    t = 0;
    while (bus.result_valid !== 1'b1 && t < 1000) begin tick(); t++; end
    $display("result pwd=%h len=%0d", bus.result_password, bus.result_len);
    n_cmp++;
    if (bus.result_valid !== 1'b1) begin n_bad++; $display("FAIL match_result_valid: got %b want 1", bus.result_valid); end
    n_cmp++;
    if (bus.result_password[159:144] !== 16'h6162) begin
      n_bad++; $display("FAIL match_pwd_head: got %h want 6162", bus.result_password[159:144]);
    end
    n_cmp++;
    if (bus.result_password[143:0] !== spaces) begin
      n_bad++; $display("FAIL match_pwd_tail: got %h want all 20", bus.result_password[143:0]);
    end
    n_cmp++;
    if (bus.result_len !== 5'd2) begin n_bad++; $display("FAIL match_len: got %0d want 2", bus.result_len); end
    // one go for the search launch plus one per received byte
    n_cmp++;
    if (go_total - g0 - 1 != 21) begin
      n_bad++; $display("FAIL match_go_acks: got %0d want 21", go_total - g0 - 1);
    end
  endtask

  task automatic test_result_hold();
    logic [159:0] p;
    logic [4:0] l;
    int g0;
    int done_cnt;
    bit stable;
    p = bus.result_password;
    l = bus.result_len;
    g0 = go_total;
    stable = 1'b1;
    bus.start = 1'b1;  // ignored while busy
    for (int k = 0; k < 100; k++) begin
      tick();
      if (bus.result_valid !== 1'b1 || bus.result_password !== p || bus.result_len !== l ||
          bus.go !== 1'b0 || bus.busy !== 1'b1) stable = 1'b0;
    end
    bus.start = 1'b0;
    n_cmp++;
    if (!stable) begin n_bad++; $display("FAIL hold_stable: got change during hold want stable"); end
    n_cmp++;
    if (go_total != g0) begin n_bad++; $display("FAIL hold_go: got %0d go acks want 0", go_total - g0); end
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.done === 1'b1) done_cnt++;
    end
    $display("result accepted, done pulses=%0d", done_cnt);
    n_cmp++;
    if (done_cnt != 1) begin n_bad++; $display("FAIL hold_done_pulse: got %0d cycles want 1", done_cnt); end
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0) begin
      n_bad++; $display("FAIL hold_idle: got busy=%b rv=%b want 0/0", bus.busy, bus.result_valid);
    end
  endtask

  task automatic test_nomatch();
    int g0;
    int done_cnt;
    bit rv_seen;
    g0 = go_total;
    done_cnt = 0;
    rv_seen = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL nomatch_busy: got %b want 1", bus.busy); end
    for (int k = 0; k < 50; k++) begin
      tick();
      if (bus.done === 1'b1) done_cnt++;
      if (bus.result_valid === 1'b1) rv_seen = 1'b1;
    end
    $display("search without match, done pulses=%0d", done_cnt);
    n_cmp++;
    if (done_cnt != 1) begin n_bad++; $display("FAIL nomatch_done: got %0d cycles want 1", done_cnt); end
    n_cmp++;
    if (bus.busy !== 1'b0 || rv_seen) begin
      n_bad++; $display("FAIL nomatch_idle: got busy=%b rv_seen=%b want 0/0", bus.busy, rv_seen);
    end
    n_cmp++;
    if (go_total - g0 != 1) begin n_bad++; $display("FAIL nomatch_go: got %0d want 1", go_total - g0); end
  endtask

  task automatic test_overlap();
    n_cmp++;
    if (overlap) begin n_bad++; $display("FAIL go_store_overlap: got overlap want none"); end
  endtask

  task automatic test_stall();
    int t;
    int hi;
    nrst = 1'b0;
    repeat (2) tick();
    nrst = 1'b1;
    tick();
    n_cmp++;
    if (bus.hash_count !== 7'd0) begin
      n_bad++; $display("FAIL stall_reset_count: got %0d want 0", bus.hash_count);
    end
    stall = 1'b1;
    t = 0;
    while (bus.hash_ready !== 1'b1 && t < 50) begin tick(); t++; end
    bus.hash_valid = 1'b1;
    bus.hash_data = 128'h00112233445566778899AABBCCDDEEFF;
    tick();
    bus.hash_valid = 1'b0;
`ifdef NTCRACK_HOST_TIMEOUT_EN
    hi = 0;
    t = 0;
    while (bus.error !== 1'b1 && t < 100) begin
      tick();
      t++;
      if (bus.error !== 1'b1 && bus.store_hash_byte === 1'b1) hi++;
    end
    $display("stalled load, error after %0d strobe cycles", hi);
    n_cmp++;
    if (bus.error !== 1'b1) begin n_bad++; $display("FAIL tmo_error: got %b want 1", bus.error); end
    n_cmp++;
    if (hi != 16) begin n_bad++; $display("FAIL tmo_cycles: got %0d want 16", hi); end
    n_cmp++;
    if (bus.store_hash_byte !== 1'b0) begin n_bad++; $display("FAIL tmo_store: got %b want 0", bus.store_hash_byte); end
`else
    hi = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.store_hash_byte === 1'b1) hi++;
    end
    $display("stalled load, strobe held %0d cycles", hi);
    n_cmp++;
    if (bus.error !== 1'b0) begin n_bad++; $display("FAIL stall_error: got %b want 0", bus.error); end
    n_cmp++;
    if (hi < 39 || bus.store_hash_byte !== 1'b1) begin
      n_bad++; $display("FAIL stall_store: got %0d held cycles want >=39 and still high", hi);
    end
`endif
    nrst = 1'b0;
    tick();
    stall = 1'b0;
    nrst = 1'b1;
    tick();
    n_cmp++;
    if (bus.error !== 1'b0 || bus.store_hash_byte !== 1'b0) begin
      n_bad++; $display("FAIL stall_recover: got err=%b store=%b want 0/0", bus.error, bus.store_hash_byte);
    end
  endtask

  initial begin
    test_reset();
    test_load_one();
    test_fill();
    test_search_match();
    test_result_hold();
    test_nomatch();
    test_overlap();
    test_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
